// File: rtl/snr_window_reporter.sv
// Windowed SNR reporter: accumulates 2^LOG2_WINDOW accepted SNR samples, then
// reports the floor average, the peak and a hysteresis "signal present" flag.
module snr_window_reporter #(
  parameter int SNR_WIDTH   = 16,
  parameter int LOG2_WINDOW = 10,
  parameter int HI_THRESH   = 20,
  parameter int LO_THRESH   = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SNR_WIDTH-1:0] snr_db,
  input  logic                        snr_valid,
  output logic                        snr_ready,
  output logic signed [SNR_WIDTH-1:0] avg_snr_db,
  output logic signed [SNR_WIDTH-1:0] peak_snr_db,
  output logic                        signal_present,
  output logic                        report_valid,
  input  logic                        report_ready
);

  localparam int ACC_WIDTH = SNR_WIDTH + LOG2_WINDOW;
  localparam logic signed [SNR_WIDTH-1:0] PEAK_INIT = {1'b1, {(SNR_WIDTH-1){1'b0}}};
  localparam logic signed [SNR_WIDTH-1:0] HI_LEVEL  = SNR_WIDTH'(HI_THRESH);
  localparam logic signed [SNR_WIDTH-1:0] LO_LEVEL  = SNR_WIDTH'(LO_THRESH);

  typedef enum logic {ACCUM, REPORT} state_t;

  state_t                        state, state_next;
  logic signed [ACC_WIDTH-1:0]   acc, acc_sum;
  logic        [LOG2_WINDOW-1:0] count;
  logic signed [SNR_WIDTH-1:0]   peak, peak_new, avg_new;
  logic                          accept, last_sample, handshake;

  assign accept      = snr_valid & snr_ready;
  assign last_sample = accept && (count == '1);
  assign handshake   = report_valid & report_ready;

  assign acc_sum  = acc + {{LOG2_WINDOW{snr_db[SNR_WIDTH-1]}}, snr_db};
  assign peak_new = (snr_db > peak) ? snr_db : peak;
  // The accumulator is exactly SNR_WIDTH+LOG2_WINDOW wide, so an arithmetic
  // shift by LOG2_WINDOW truncated to SNR_WIDTH is simply its top bits.
  assign avg_new  = acc_sum[LOG2_WINDOW +: SNR_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (last_sample) state_next = REPORT;
      REPORT:  if (report_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // snr_ready is gated by reset so upstream never sees a ready during reset.
  always_comb begin
    snr_ready    = (state == ACCUM) && reset;
    report_valid = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc            <= '0;
      count          <= '0;
      peak           <= PEAK_INIT;
      avg_snr_db     <= '0;
      peak_snr_db    <= '0;
      signal_present <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_sum;
        count <= count + LOG2_WINDOW'(1);
        peak  <= peak_new;
        if (last_sample) begin
          avg_snr_db  <= avg_new;
          peak_snr_db <= peak_new;
          if (avg_new >= HI_LEVEL)      signal_present <= 1'b1;
          else if (avg_new <= LO_LEVEL) signal_present <= 1'b0;
        end
      end
      if (handshake) begin
        acc   <= '0;
        count <= '0;
        peak  <= PEAK_INIT;
      end
    end
  end

endmodule

// File: tb/tb_snr_window_reporter.sv
// Self-checking bench for snr_window_reporter: directed scenarios plus a
// randomized phase, all compared against a window-level reference model.
module tb_snr_window_reporter;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int HI = 20;
  localparam int LO = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] snr_db;
  logic                snr_valid;
  logic                snr_ready;
  logic signed [W-1:0] avg_snr_db;
  logic signed [W-1:0] peak_snr_db;
  logic                signal_present;
  logic                report_valid;
  logic                report_ready;

  always #5 clk = ~clk;

  snr_window_reporter #(
    .SNR_WIDTH(W), .LOG2_WINDOW(L), .HI_THRESH(HI), .LO_THRESH(LO)
  ) dut (
    .clk(clk), .reset(reset), .snr_db(snr_db), .snr_valid(snr_valid),
    .snr_ready(snr_ready), .avg_snr_db(avg_snr_db), .peak_snr_db(peak_snr_db),
    .signal_present(signal_present), .report_valid(report_valid),
    .report_ready(report_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a list of samples in the current window and the last report.
  int q[$];
  bit m_rv;
  int m_avg, m_peak;
  bit m_sp;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    int r;
    r = s / d;
    if ((s % d != 0) && (s < 0)) r = r - 1;
    return r;
  endfunction

  task automatic model_step();
    int sum, mx;
    if (!reset) begin
      q.delete();
      m_rv = 0; m_avg = 0; m_peak = 0; m_sp = 0;
    end else if (m_rv) begin
      if (report_ready) m_rv = 0;
    end else if (snr_valid) begin
      q.push_back(int'(snr_db));
      if (q.size() == N) begin
        sum = 0;
        mx  = q[0];
        foreach (q[i]) begin
          sum += q[i];
          if (q[i] > mx) mx = q[i];
        end
        m_avg  = floor_div(sum, N);
        m_peak = mx;
        if (m_avg >= HI)      m_sp = 1;
        else if (m_avg <= LO) m_sp = 0;
        m_rv = 1;
        q.delete();
      end
    end
  endtask

  // One clock: advance the model on pre-edge inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("report_valid", report_valid, m_rv);
    chk("snr_ready", snr_ready, (!m_rv && reset));
    chk("avg_snr_db", avg_snr_db, m_avg);
    chk("peak_snr_db", peak_snr_db, m_peak);
    chk("signal_present", signal_present, m_sp);
  endtask

  task automatic send(input int v);
    snr_valid = 1'b1;
    snr_db    = W'(v);
    tick();
    snr_valid = 1'b0;
  endtask

  task automatic send_window(input int v0, input int v1, input int v2, input int v3);
    send(v0); send(v1); send(v2); send(v3);
  endtask

  task automatic idle(input int n);
    snr_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset        = 1'b0;
    snr_valid    = 1'b0;
    snr_db       = '0;
    report_ready = 1'b1;
    tick();
    chk("rst_avg", avg_snr_db, 0);
    chk("rst_peak", peak_snr_db, 0);
    chk("rst_ready", snr_ready, 0);
    reset = 1'b1;
    idle(2);

    // 1: basic window, single-cycle report
    send(10); send(20); send(30);
    chk("t1_rv_early", report_valid, 0);
    send(40);
    chk("t1_rv", report_valid, 1);
    chk("t1_ready_low", snr_ready, 0);
    chk("t1_avg", avg_snr_db, 25);
    chk("t1_peak", peak_snr_db, 40);
    chk("t1_sp", signal_present, 1);
    idle(1);
    chk("t1_rv_drop", report_valid, 0);
    chk("t1_ready_back", snr_ready, 1);

    // 2: negative samples, floor rounding
    send_window(-3, -4, -5, -6);
    chk("t2_avg", avg_snr_db, -5);
    chk("t2_peak", peak_snr_db, -3);
    chk("t2_sp", signal_present, 0);
    idle(1);

    // 3: hysteresis 25,15,12,16
    send_window(25, 25, 25, 25); chk("t3_sp25", signal_present, 1); idle(1);
    send_window(15, 15, 15, 15); chk("t3_sp15", signal_present, 1); idle(1);
    send_window(12, 12, 12, 12); chk("t3_sp12", signal_present, 0); idle(1);
    send_window(16, 16, 16, 16); chk("t3_sp16", signal_present, 0); idle(1);

    // 4: report backpressure with upstream pushing
    report_ready = 1'b0;
    send_window(30, 30, 30, 30);
    chk("t4_rv", report_valid, 1);
    for (int i = 0; i < 5; i++) begin
      snr_valid = 1'b1;
      snr_db    = W'(99);
      tick();
      chk("t4_hold_rv", report_valid, 1);
      chk("t4_hold_ready", snr_ready, 0);
      chk("t4_hold_avg", avg_snr_db, 30);
      chk("t4_hold_peak", peak_snr_db, 30);
    end
    report_ready = 1'b1;
    tick();
    chk("t4_handshake", report_valid, 0);
    snr_valid = 1'b0;
    send(0); send(4); send(8);
    chk("t4_no_early", report_valid, 0);
    send(12);
    chk("t4_rv2", report_valid, 1);
    chk("t4_avg", avg_snr_db, 6);
    chk("t4_peak", peak_snr_db, 12);
    chk("t4_sp", signal_present, 0);
    idle(1);

    // 5: reset mid-window, then gapped samples
    send(100); send(100);
    reset = 1'b0;
    tick();
    chk("t5_rst_avg", avg_snr_db, 0);
    chk("t5_rst_peak", peak_snr_db, 0);
    chk("t5_rst_sp", signal_present, 0);
    chk("t5_rst_rv", report_valid, 0);
    chk("t5_rst_ready", snr_ready, 0);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, 3));
      send(8);
    end
    chk("t5_rv", report_valid, 1);
    chk("t5_avg", avg_snr_db, 8);
    chk("t5_peak", peak_snr_db, 8);
    idle(1);

    // 6: full-scale samples, no wrap
    send_window(32767, 32767, 32767, 32767);
    chk("t6_avg", avg_snr_db, 32767);
    chk("t6_peak", peak_snr_db, 32767);
    idle(1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      snr_valid    = ($urandom_range(0, 2) != 0);
      snr_db       = W'($urandom);
      report_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
